ieee_log_result_buffer: RTL and testbench
=========================================

# ieee_log_result_buffer

Credit-based stream adapter that wraps the fixed-latency IEEE 754 logarithm datapath with valid/ready handshakes. It forwards accepted operands to the logarithm unit and tracks each operand's progress through the unit's pipeline. It captures each result as it emerges into a small FIFO and presents it downstream. Upstream is back-pressured by a credit count, so no result produced by the unit is ever lost.

## Interface
- DataWidth, 32: IEEE 754 operand/result width; must equal the log unit's DataWidth.
- Latency, 2: cycles from operand at log unit input to result at log unit output; must equal the log unit's Latency; 0 allowed.
- Depth, 4: result FIFO entries and credit limit; must be ≥ 1; ≥ Latency+2 required for 1 result/cycle throughput.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- flush_i  in  1  synchronous flush: drop in-flight and buffered results.
- in_valid_i  in  1  upstream operand valid.
- in_ready_o  out  1  upstream operand ready.
- in_data_i  in  DataWidth  IEEE 754 operand.
- log_operand_o  out  DataWidth  to log unit operand input; equals in_data_i combinationally.
- log_result_i  in  DataWidth  from log unit result output.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DataWidth  IEEE 754 result, in issue order.
- count_o  out  $clog2(Depth+1)  occupancy = in-flight + buffered.

## Operation
- Issue: fire_in = in_valid_i & in_ready_o. Operand passes to log unit that cycle.
- Track: Latency-bit valid shift register; bit 0 ← fire_in, shifts every cycle.
- Capture: when the last stage is set (Latency=0: when fire_in is set), push log_result_i into the FIFO that cycle.
- FIFO: circular buffer, Depth entries.
  - Write pointer and read pointer wrap from Depth-1 to 0; Depth need not be a power of 2.
  - out_data_o = mem[rd_ptr]; out_valid_o = (fifo_count != 0).
- Pop: fire_out = out_valid_o & out_ready_i advances rd_ptr.
- Simultaneous push and pop: both occur; fifo_count unchanged; pointers both advance.
  - A push into an empty FIFO is not visible the same cycle; there is no bypass.
- Credits: occ = popcount(shift register) + fifo_count, registered as count_o.
  - in_ready_o = (occ < Depth) & ~flush_i.
  - in_ready_o is independent of out_ready_i; there is no combinational ready path.
- Invariant: a push never finds the FIFO full. Verification asserts this.
- Flush (flush_i=1 for one cycle or more):
  - On the next edge, clear the shift register, fifo_count and both pointers.
  - Any result exiting during the flush cycle is dropped.
  - No issue occurs during flush because in_ready_o=0.
- Reset mid-operation: state clears immediately.
  - Results still in the log unit's pipeline emerge later but are ignored, because their tracking bits are gone.
- No interpretation of data: NaN, ±inf and zero results pass through bit-exact.

## Timing
- Reset values: out_valid_o=0, in_ready_o=1 (when flush_i=0), count_o=0, out_data_o=don't-care; pointers and shift register are 0.
- Operand accepted in cycle t → pushed at end of cycle t+Latency → out_valid_o=1 in cycle t+Latency+1 if the FIFO was empty. Total latency = Latency+1.
- Throughput: one result/cycle sustained when Depth ≥ Latency+2 and out_ready_i=1.
- With out_ready_i=0: at most Depth operands accepted, then in_ready_o=0 until a pop.
  - After a pop, in_ready_o rises in the following cycle.
- out_data_o and out_valid_o are held stable while out_valid_o=1 and out_ready_i=0.

## Test plan
- Single op, DataWidth=32, Latency=2: in 0x3F800000 (1.0) at cycle 0 → out_valid_o=1 at cycle 3 with 0x00000000. Specials: 0x00000000→0xFF800000, 0xBF800000→NaN (exp all ones, mantissa≠0), 0x7F800000→0x7F800000.
- Back-pressure, Depth=4: out_ready_i=0, stream 6 operands.
  - Exactly 4 accepted; in_ready_o=0 thereafter; count_o=4.
  - Raise out_ready_i → 6 results in order.
  - No push is ever made into a full FIFO.
- Throughput: 100 back-to-back ops with out_ready_i=1 → in_ready_o never drops, 100 results on consecutive cycles, in order, each matching the reference model.
- Random out_ready_i (50%) and in_valid_i (70%), 2000 ops → every result delivered exactly once, in order, and count_o is never more than Depth.
- Async reset with 2 in flight and 1 buffered → out_valid_o=0 and count_o=0 immediately, and no stray out_valid_o in the next Latency+2 cycles.
- flush_i pulse with 2 in flight:
  - in_ready_o=0 in the flush cycle and out_valid_o=0 afterward, with no stale results.
  - An op issued the cycle after the flush produces exactly one correct result.

Source files
------------

// File: rtl/ieee_log_result_buffer.sv
// ieee_log_result_buffer
// Valid/ready stream wrapper around a fixed-latency IEEE 754 logarithm unit.
// Operands go straight to the log unit; a valid shift register follows each
// operand through the unit's pipeline, and the emerging result is captured
// into a circular FIFO. Upstream is throttled by a credit count so that
// every result the unit produces always has a FIFO slot waiting for it.
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high in that cycle. A producer must hold valid and its data
// steady until the transfer. Ready may be raised or lowered at any time.
// in_ready_o never depends on out_ready_i.
module ieee_log_result_buffer #(
    parameter int DataWidth = 32,
    parameter int Latency   = 2,
    parameter int Depth     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DataWidth-1:0]         in_data_i,
    output logic [DataWidth-1:0]         log_operand_o,
    input  logic [DataWidth-1:0]         log_result_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DataWidth-1:0]         out_data_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    // Keep the tracking vector at least one bit wide so Latency=0 still elaborates.
    localparam int TrkW = (Latency > 0) ? Latency : 1;

    logic                 fire_in;
    logic                 fire_out;
    logic                 push;

    logic [TrkW-1:0]      trk_q,      trk_d;
    logic [PtrW-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0]      count_q,    count_d;
    logic [CntW-1:0]      inflight_d;
    logic [DataWidth-1:0] mem_q [Depth];

    // Circular pointer advance; Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Credit check uses registered occupancy only, so there is no path from
    // out_ready_i to in_ready_o; a pop frees its credit on the following cycle.
    assign in_ready_o    = (count_q < CntW'(Depth)) & ~flush_i;
    assign fire_in       = in_valid_i & in_ready_o;
    assign log_operand_o = in_data_i;

    assign out_valid_o   = (fifo_cnt_q != '0);
    assign out_data_o    = mem_q[rd_ptr_q];
    assign fire_out      = out_valid_o & out_ready_i;
    assign count_o       = count_q;

    // Tracking bit per pipeline stage; the last stage marks a result at the log unit output.
    generate
        if (Latency == 0) begin : g_no_pipe
            assign push  = fire_in;
            assign trk_d = '0;
        end else begin : g_pipe
            assign push  = trk_q[TrkW-1];
            assign trk_d = flush_i ? '0 : ((trk_q << 1) | TrkW'(fire_in));
        end
    endgenerate

    // FIFO pointer/count update and next-cycle occupancy (in flight + buffered).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        inflight_d = '0;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (fire_out) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !fire_out) begin
                fifo_cnt_d = fifo_cnt_q + CntW'(1);
            end else if (!push && fire_out) begin
                fifo_cnt_d = fifo_cnt_q - CntW'(1);
            end
        end

        for (int i = 0; i < TrkW; i++) begin
            inflight_d = inflight_d + CntW'(trk_d[i]);
        end
        count_d = inflight_d + fifo_cnt_d;
    end

    // Control state; reset clears everything, so late results from the log unit are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trk_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            trk_q      <= trk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            count_q    <= count_d;
        end
    end

    // Result storage; contents need no reset because out_valid_o gates them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= log_result_i;
        end
    end

endmodule

// File: tb/tb_ieee_log_result_buffer.sv
// Directed bench for ieee_log_result_buffer with a behavioural stand-in for
// the log unit (fixed Latency-stage pipeline) and an in-order scoreboard.
module tb_ieee_log_result_buffer;

  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] log_operand;
  logic [DW-1:0] log_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  ieee_log_result_buffer #(
    .DataWidth (DW),
    .Latency   (LAT),
    .Depth     (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .log_operand_o (log_operand),
    .log_result_i  (log_result),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .count_o       (count)
  );

  // Stand-in log unit: IEEE specials are exact; other values map through a
  // fixed scramble, since the adapter only has to move bits unchanged.
  function automatic logic [DW-1:0] log_model(input logic [DW-1:0] x);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return x | 32'h0040_0000;
    if (x[30:0] == 31'd0) return 32'hFF80_0000;
    if (x[31]) return 32'h7FC0_0000;
    if (x == 32'h7F80_0000) return 32'h7F80_0000;
    if (x == 32'h3F80_0000) return 32'h0000_0000;
    return {1'b0, x[30:0]} ^ 32'h1234_5678;
  endfunction

  logic [DW-1:0] lpipe [LAT];
  always @(posedge clk) begin
    lpipe[0] <= log_model(log_operand);
    for (int i = 1; i < LAT; i++) lpipe[i] <= lpipe[i-1];
  end
  assign log_result = lpipe[LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ops[$];
  int op_idx    = 0;
  int cyc_no    = 0;
  int n_pop     = 0;
  int first_pop = -1;
  int last_pop  = -1;
  int n_stall   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at the falling edge: records transfers that the next rising edge commits.
  task automatic observe();
    if (in_valid && in_ready) begin
      exp_q.push_back(log_model(in_data));
      op_idx++;
    end
    if (out_valid && out_ready) begin
      n_pop++;
      if (first_pop < 0) first_pop = cyc_no;
      last_pop = cyc_no;
      if (exp_q.size() == 0) check("unexpected_result", out_data, 32'hXXXX_XXXX);
      else check("result", out_data, exp_q.pop_front());
    end
    if (in_valid && !in_ready) n_stall++;
    check("count_bound", DW'(count <= CW'(DEPTH)), 1);
  endtask

  task automatic finish_cycle();
    observe();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic cyc();
    @(negedge clk);
    finish_cycle();
  endtask

  // ---------------- driver tasks ----------------
  task automatic single_op(input logic [DW-1:0] op, input logic [DW-1:0] res, input string tag);
    in_valid  = 1'b1;
    in_data   = op;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_operand"}, log_operand, op);
    finish_cycle();
    in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check({tag, "_early_valid"}, out_valid, 0);
      check({tag, "_inflight_count"}, count, 1);
      finish_cycle();
    end
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, res);
    out_ready = 1'b1;
    finish_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drained"}, out_valid, 0);
    check({tag, "_count"}, count, 0);
    finish_cycle();
  endtask

  task automatic run_stream(input int pv, input int pr, input int budget, input string tag);
    int b;
    b = 0;
    while ((op_idx < ops.size() || exp_q.size() != 0) && b < budget) begin
      in_valid  = (op_idx < ops.size()) && ($urandom_range(99) < pv);
      in_data   = in_valid ? ops[op_idx] : $urandom;
      out_ready = ($urandom_range(99) < pr);
      cyc();
      b++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_completed_in_budget"}, DW'(b < budget), 1);
  endtask

  task automatic new_phase();
    ops.delete();
    exp_q.delete();
    op_idx    = 0;
    n_pop     = 0;
    first_pop = -1;
    last_pop  = -1;
    n_stall   = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_count", count, 0);
    @(posedge clk);
    #1;

    // Single operations, including IEEE specials.
    new_phase();
    single_op(32'h3F80_0000, 32'h0000_0000, "log_one");
    single_op(32'h0000_0000, 32'hFF80_0000, "log_zero");
    single_op(32'hBF80_0000, 32'h7FC0_0000, "log_neg_one");
    single_op(32'h7F80_0000, 32'h7F80_0000, "log_inf");

    // Back-pressure: six operands offered with the output stalled.
    new_phase();
    ops.push_back(32'h4000_0000);
    ops.push_back(32'h3F00_0000);
    ops.push_back(32'h4120_0000);
    ops.push_back(32'h7FC0_0001);
    ops.push_back(32'h8000_0000);
    ops.push_back(32'h0000_0001);
    for (int c = 0; c < 8; c++) begin
      in_valid = (op_idx < ops.size());
      in_data  = in_valid ? ops[op_idx] : '0;
      cyc();
    end
    in_valid = 1'b1;
    in_data  = ops[op_idx];
    @(negedge clk);
    check("bp_accepted", op_idx, 4);
    check("bp_ready_low", in_ready, 0);
    check("bp_count", count, 4);
    check("bp_head_valid", out_valid, 1);
    check("bp_head_data", out_data, log_model(32'h4000_0000));
    finish_cycle();
    @(negedge clk);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", out_data, log_model(32'h4000_0000));
    out_ready = 1'b1;
    check("bp_ready_in_pop_cycle", in_ready, 0);
    finish_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_after_pop", in_ready, 1);
    finish_cycle();
    run_stream(100, 100, 100, "bp");
    check("bp_results", n_pop, 6);

    // Throughput: 100 back-to-back operands, output always ready.
    new_phase();
    for (int i = 0; i < 100; i++) ops.push_back($urandom);
    run_stream(100, 100, 400, "tput");
    check("tput_results", n_pop, 100);
    check("tput_no_stall", n_stall, 0);
    check("tput_consecutive", last_pop - first_pop, 99);

    // Random valid/ready mix.
    new_phase();
    for (int i = 0; i < 2000; i++) ops.push_back($urandom);
    run_stream(70, 50, 20000, "rand");
    check("rand_results", n_pop, 2000);

    // Asynchronous reset with two in flight and one buffered.
    new_phase();
    in_valid = 1'b1; in_data = 32'h4040_0000; cyc();
    in_valid = 1'b0; cyc();
    in_valid = 1'b1; in_data = 32'h4080_0000; cyc();
    in_valid = 1'b1; in_data = 32'h40A0_0000; cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_count", count, 3);
    check("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check("rst_no_stray_valid", out_valid, 0);
      finish_cycle();
    end
    out_ready = 1'b0;

    // Flush with two operands in flight.
    new_phase();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h4100_0000; cyc();
    in_valid = 1'b1; in_data = 32'h4110_0000; cyc();
    flush    = 1'b1;
    in_data  = 32'h4120_0000;
    @(negedge clk);
    check("flush_ready_low", in_ready, 0);
    check("flush_pre_count", count, 2);
    finish_cycle();
    flush = 1'b0;
    exp_q.delete();
    n_pop = 0;
    in_valid = 1'b1;
    in_data  = 32'h42C8_0000;
    @(negedge clk);
    check("flush_post_count", count, 0);
    check("flush_post_valid", out_valid, 0);
    check("flush_post_ready", in_ready, 1);
    finish_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < LAT) check("flush_no_stale", out_valid, 0);
      if (k == LAT) check("flush_new_result", out_data, log_model(32'h42C8_0000));
      finish_cycle();
    end
    check("flush_one_result", n_pop, 1);
    check("flush_queue_empty", exp_q.size(), 0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
